// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter slice: unit codes,
// writeback packet layout and the default widths.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_WIDTH = 6;
    localparam int DATA_WIDTH     = 64;
    localparam int FIFO_DEPTH     = 4;

    localparam logic [1:0] FX_UNIT_CODE     = 2'd0;
    localparam logic [1:0] FP_UNIT_CODE     = 2'd1;
    localparam logic [1:0] LDST_UNIT_CODE   = 2'd2;
    localparam logic [1:0] BRANCH_UNIT_CODE = 2'd3;

    typedef struct packed {
        logic                        en1;
        logic [0:REG_ADDR_WIDTH-1]   addr1;
        logic [0:DATA_WIDTH-1]       val1;
        logic                        en2;
        logic [0:REG_ADDR_WIDTH-1]   addr2;
        logic [0:DATA_WIDTH-1]       val2;
    } wb_packet_t;

    // A packet with neither write enabled carries nothing and is never queued.
    function automatic logic packet_valid(wb_packet_t p);
        return p.en1 | p.en2;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback bus between the FX / LdSt units, the arbiter and the register file.
// master: the producing/consuming environment; slave: the arbiter.
interface writeback_arbiter_if #(
    parameter int regAddrWidth = 6,
    parameter int dataWidth    = 64
);
    logic                      fxReg1WritebackEnable_i;
    logic                      fxReg2WritebackEnable_i;
    logic [0:regAddrWidth-1]   fxReg1WritebackAddress_i;
    logic [0:regAddrWidth-1]   fxReg2WritebackAddress_i;
    logic [0:dataWidth-1]      fxReg1WritebackVal_i;
    logic [0:dataWidth-1]      fxReg2WritebackVal_i;

    logic                      ldStReg1WritebackEnable_i;
    logic                      ldStReg2WritebackEnable_i;
    logic [0:regAddrWidth-1]   ldStReg1WritebackAddress_i;
    logic [0:regAddrWidth-1]   ldStReg2WritebackAddress_i;
    logic [0:dataWidth-1]      ldStReg1WritebackVal_i;
    logic [0:dataWidth-1]      ldStReg2WritebackVal_i;

    logic                      regFileWrite1Enable_o;
    logic                      regFileWrite2Enable_o;
    logic [0:regAddrWidth-1]   regFileWrite1Address_o;
    logic [0:regAddrWidth-1]   regFileWrite2Address_o;
    logic [0:dataWidth-1]      regFileWrite1Val_o;
    logic [0:dataWidth-1]      regFileWrite2Val_o;
    logic [0:1]                functionalUnitCode_o;
    logic                      fxStall_o;
    logic                      ldStStall_o;
    logic                      overflow_o;

    modport master (
        output fxReg1WritebackEnable_i, fxReg2WritebackEnable_i,
               fxReg1WritebackAddress_i, fxReg2WritebackAddress_i,
               fxReg1WritebackVal_i, fxReg2WritebackVal_i,
               ldStReg1WritebackEnable_i, ldStReg2WritebackEnable_i,
               ldStReg1WritebackAddress_i, ldStReg2WritebackAddress_i,
               ldStReg1WritebackVal_i, ldStReg2WritebackVal_i,
        input  regFileWrite1Enable_o, regFileWrite2Enable_o,
               regFileWrite1Address_o, regFileWrite2Address_o,
               regFileWrite1Val_o, regFileWrite2Val_o,
               functionalUnitCode_o, fxStall_o, ldStStall_o, overflow_o
    );

    modport slave (
        input  fxReg1WritebackEnable_i, fxReg2WritebackEnable_i,
               fxReg1WritebackAddress_i, fxReg2WritebackAddress_i,
               fxReg1WritebackVal_i, fxReg2WritebackVal_i,
               ldStReg1WritebackEnable_i, ldStReg2WritebackEnable_i,
               ldStReg1WritebackAddress_i, ldStReg2WritebackAddress_i,
               ldStReg1WritebackVal_i, ldStReg2WritebackVal_i,
        output regFileWrite1Enable_o, regFileWrite2Enable_o,
               regFileWrite1Address_o, regFileWrite2Address_o,
               regFileWrite1Val_o, regFileWrite2Val_o,
               functionalUnitCode_o, fxStall_o, ldStStall_o, overflow_o
    );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Per-source packet FIFO (module wb_packet_fifo). Head is read combinationally so
// the arbiter can pop and forward it in the same cycle; caller never pops when empty.
module wb_packet_fifo #(
    parameter int fifoDepth   = 4,
    parameter int packetWidth = 8
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              push,
    input  logic                              pop,
    input  logic [packetWidth-1:0]            din,
    output logic [packetWidth-1:0]            head,
    output logic [$clog2(fifoDepth+1)-1:0]    count,
    output logic                              full
);
    localparam int PTR_W = $clog2(fifoDepth);
    localparam int CNT_W = $clog2(fifoDepth + 1);

    logic [packetWidth-1:0] mem_reg [fifoDepth];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(fifoDepth));
endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: FX and LdSt packets queue per source and one is
// granted per cycle to the register file. Optional macro: WB_ARBITER_BYPASS_EN.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int         fifoDepth    = FIFO_DEPTH,
    parameter int         regAddrWidth = REG_ADDR_WIDTH,
    parameter int         dataWidth    = DATA_WIDTH,
    parameter logic [1:0] FXUnitCode   = FX_UNIT_CODE,
    parameter logic [1:0] LdStUnitCode = LDST_UNIT_CODE
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    writeback_arbiter_if.slave    wb
);
    localparam int CNT_W = $clog2(fifoDepth + 1);

    wb_packet_t        pkt_in [2];
    wb_packet_t        head   [2];
    logic [CNT_W-1:0]  count  [2];
    logic [1:0]        push_req, push_acc, pop, full, not_empty, drop, stall;
    logic [1:0]        grant, bypass;
    logic              ptr_reg, ptr_toggle;
    logic              sel_src, load_out;
    wb_packet_t        sel_pkt;

    logic                     en1_reg, en2_reg, overflow_reg;
    logic [0:regAddrWidth-1]  addr1_reg, addr2_reg;
    logic [0:dataWidth-1]     val1_reg, val2_reg;
    logic [1:0]               code_reg;

    assign pkt_in[0] = '{en1: wb.fxReg1WritebackEnable_i,   addr1: wb.fxReg1WritebackAddress_i,
                         val1: wb.fxReg1WritebackVal_i,     en2: wb.fxReg2WritebackEnable_i,
                         addr2: wb.fxReg2WritebackAddress_i, val2: wb.fxReg2WritebackVal_i};
    assign pkt_in[1] = '{en1: wb.ldStReg1WritebackEnable_i,   addr1: wb.ldStReg1WritebackAddress_i,
                         val1: wb.ldStReg1WritebackVal_i,     en2: wb.ldStReg2WritebackEnable_i,
                         addr2: wb.ldStReg2WritebackAddress_i, val2: wb.ldStReg2WritebackVal_i};

    // Source 0 is FX, source 1 is LdSt throughout.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign push_req[gi]  = packet_valid(pkt_in[gi]);
        assign not_empty[gi] = (count[gi] != '0);
        assign push_acc[gi]  = push_req[gi] & ~bypass[gi] & (~full[gi] | pop[gi]);
        assign drop[gi]      = push_req[gi] & ~bypass[gi] & full[gi] & ~pop[gi];
        assign stall[gi]     = (count[gi] >= CNT_W'(fifoDepth - 1));

        wb_packet_fifo #(
            .fifoDepth   (fifoDepth),
            .packetWidth ($bits(wb_packet_t))
        ) u_fifo (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .push    (push_acc[gi]),
            .pop     (pop[gi]),
            .din     (pkt_in[gi]),
            .head    (head[gi]),
            .count   (count[gi]),
            .full    (full[gi])
        );
    end

    // Bypass is only considered when both queues are empty, so it never
    // competes with a FIFO head.
    always_comb begin
        grant      = '0;
        bypass     = '0;
        ptr_toggle = 1'b0;
        if (&not_empty) begin
            grant[ptr_reg] = 1'b1;
            ptr_toggle     = 1'b1;
        end else if (not_empty[0]) begin
            grant[0] = 1'b1;
        end else if (not_empty[1]) begin
            grant[1] = 1'b1;
        end
`ifdef WB_ARBITER_BYPASS_EN
        else if (&push_req) begin
            bypass[ptr_reg] = 1'b1;
            ptr_toggle      = 1'b1;
        end else begin
            bypass = push_req;
        end
`endif
    end

    assign pop      = grant;
    assign sel_src  = grant[1] | bypass[1];
    assign load_out = |{grant, bypass};
    assign sel_pkt  = (|bypass) ? pkt_in[sel_src] : head[sel_src];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            en1_reg      <= 1'b0;
            en2_reg      <= 1'b0;
            addr1_reg    <= '0;
            addr2_reg    <= '0;
            val1_reg     <= '0;
            val2_reg     <= '0;
            code_reg     <= '0;
            overflow_reg <= 1'b0;
            ptr_reg      <= 1'b0;
        end else begin
            overflow_reg <= overflow_reg | (|drop);
            ptr_reg      <= ptr_reg ^ ptr_toggle;
            if (load_out) begin
                // Two writes to one register: the port-2 value wins.
                en1_reg   <= sel_pkt.en1 & ~(sel_pkt.en2 & (sel_pkt.addr1 == sel_pkt.addr2));
                en2_reg   <= sel_pkt.en2;
                addr1_reg <= sel_pkt.addr1;
                addr2_reg <= sel_pkt.addr2;
                val1_reg  <= sel_pkt.val1;
                val2_reg  <= sel_pkt.val2;
                code_reg  <= sel_src ? LdStUnitCode : FXUnitCode;
            end else begin
                en1_reg <= 1'b0;
                en2_reg <= 1'b0;
            end
        end
    end

    assign wb.regFileWrite1Enable_o  = en1_reg;
    assign wb.regFileWrite2Enable_o  = en2_reg;
    assign wb.regFileWrite1Address_o = addr1_reg;
    assign wb.regFileWrite2Address_o = addr2_reg;
    assign wb.regFileWrite1Val_o     = val1_reg;
    assign wb.regFileWrite2Val_o     = val2_reg;
    assign wb.functionalUnitCode_o   = code_reg;
    assign wb.fxStall_o              = stall[0];
    assign wb.ldStStall_o            = stall[1];
    assign wb.overflow_o             = overflow_reg;
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Sits directly downstream of the fixed-point unit and the load/store unit, between their writeback output ports and the architected register file write ports.
- Each unit produces a writeback packet: up to two register writes, each with enable, 6-bit address and 64-bit value.
- Buffers each unit's packets in its own FIFO and grants one packet per cycle to the register file's two write ports, using round-robin arbitration.
- Back-pressures each unit with a stall.

Parameters:
fifoDepth, 4, entries per source FIFO (power of two, >= 2)
regAddrWidth, 6, writeback register address width
dataWidth, 64, writeback value width
FXUnitCode, 0, functional unit code reported for fixed-point grants
LdStUnitCode, 2, functional unit code reported for load/store grants

Ports:
clock_i  in  1  single clock; all state updates on rising edge
reset_i  in  1  synchronous, active-high reset
fxReg1WritebackEnable_i, fxReg2WritebackEnable_i  in  1 each  fixed-point write enables
fxReg1WritebackAddress_i, fxReg2WritebackAddress_i  in  [0:regAddrWidth-1]  fixed-point write addresses
fxReg1WritebackVal_i, fxReg2WritebackVal_i  in  [0:dataWidth-1]  fixed-point write values
ldStReg1WritebackEnable_i, ldStReg2WritebackEnable_i, ldStReg1WritebackAddress_i, ldStReg2WritebackAddress_i, ldStReg1WritebackVal_i, ldStReg2WritebackVal_i  in  as above  load/store packet
regFileWrite1Enable_o, regFileWrite2Enable_o  out  1 each  register file write enables
regFileWrite1Address_o, regFileWrite2Address_o  out  [0:regAddrWidth-1]  register file write addresses
regFileWrite1Val_o, regFileWrite2Val_o  out  [0:dataWidth-1]  register file write values
functionalUnitCode_o  out  [0:1]  unit code of the packet on the outputs
fxStall_o, ldStStall_o  out  1 each  per-source back-pressure
overflow_o  out  1  sticky error: a packet was dropped

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FIFOs empty, priority pointer = FX, overflow_o = 0. Reset overrides any push or pop in the same cycle. Packets in flight are discarded.
- Push:
  - A source pushes at an edge when either of its enables is 1. Packets with both enables 0 are ignored.
  - Accepted if that FIFO's count < fifoDepth.
  - If the FIFO is full, the packet is dropped and overflow_o is set to 1 until reset.
  - A push and a pop on the same FIFO in the same cycle: the count is unchanged. The pop is evaluated first, so a push into a full FIFO that is popping this cycle is accepted.
- Arbitration (each edge), over FIFO heads as they stood before the edge:
  - Neither FIFO non-empty: output enables go to 0; address, value and functionalUnitCode_o hold.
  - One FIFO non-empty: grant it.
  - Both non-empty: grant the source named by the pointer, then toggle the pointer. The pointer changes only on a contended grant.
  - Granted head is popped and loaded into the output registers; functionalUnitCode_o is set to FXUnitCode or LdStUnitCode.
- Latency: a packet pushed at edge k reaches the outputs at edge k+1 at the earliest, i.e. 2 cycles from input to register-file write.
- Same-address rule: if a packet has both enables set and equal addresses, only write port 2 is driven; regFileWrite1Enable_o = 0.
- Cross-source ordering is not enforced. Issue logic guarantees that no two in-flight packets target the same register.
- Stall: fxStall_o / ldStStall_o = 1 in every cycle where that FIFO's count >= fifoDepth-1 (registered). This gives one push of slack, so a unit that samples stall one cycle late never overflows.
- Pointer: 1 bit, wraps FX -> LdSt -> FX.

Optional Feature:
- Macro: WB_ARBITER_BYPASS_EN.
- Defined: when the target FIFO is empty and this source would win arbitration this cycle, the incoming packet goes straight to the output registers at the same edge (1-cycle latency) and is not written to the FIFO.
  - A source would win if the other FIFO is empty and the other source is not also bypassing.
  - If both sources bypass simultaneously, the pointer picks one; the loser is pushed into its FIFO.
- Undefined: every packet passes through its FIFO (2-cycle latency).

Decomposition:
- Shared package:
  - Functional unit code constants (FXUnitCode=0, FPUnitCode=1, LdStUnitCode=2, BranchUnitCode=3).
  - Typedef wb_packet_t: en1, addr1, val1, en2, addr2, val2.
  - Register address width constant.
- Sub-module wb_packet_fifo (parameters fifoDepth and packet width), instantiated once per source. Interface: push, pop, head, count, full.

Test Plan:
- Reset: assert reset_i for 2 cycles while both sources push -> all outputs 0, stalls 0, overflow_o 0; first post-reset grant is FX.
- Single LdSt packet (reg1 addr 5 val 0x1122334455667788, reg2 addr 3 val 0x100) at edge 0 -> edge 1: regFileWrite1 = (1, 5, 0x1122...88), regFileWrite2 = (1, 3, 0x100), functionalUnitCode_o = 2.
- Both sources push every cycle for 8 cycles -> grants alternate FX, LdSt, FX, ...; stalls rise when count reaches 3; with stall honoured, overflow_o stays 0 and all 8 + 8 packets are delivered.
- Force a 5th FX push into a full depth-4 FIFO with no pop -> packet dropped, overflow_o = 1 and stays 1 until reset.
- Packet with both enables set, addresses both 7, values 0xA and 0xB -> only port 2 is written (7, 0xB); regFileWrite1Enable_o = 0.
- With WB_ARBITER_BYPASS_EN: a single FX packet into an idle arbiter at edge 0 appears on the outputs at edge 0; without the macro it appears at edge 1.
